// File: rtl/insert_sort_pkg.sv
// Shared types and helpers for the sequential insertion sorter.
package insert_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of one original-position index for an n-entry sort.
  function automatic int unsigned pos_w(input int unsigned n);
    return 32'($clog2(n)) + 32'd1;
  endfunction

endpackage

// File: rtl/insert_sort_cell.sv
// One slot of the sorted array: holds a value/position pair and decides each
// insertion cycle whether to keep, take the left neighbour, or load the new element.
module insert_sort_cell #(
  parameter int unsigned VW = 16,
  parameter int unsigned PW = 7,
  parameter int unsigned KW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [KW-1:0] i_slot,
  input  logic [KW-1:0] i_k,
  input  logic [VW-1:0] i_new_val,
  input  logic [PW-1:0] i_new_pos,
  input  logic [VW-1:0] i_left_val,
  input  logic [PW-1:0] i_left_pos,
  input  logic          i_gt_left,
  output logic          o_gt_c,
  output logic [VW-1:0] o_val,
  output logic [PW-1:0] o_pos
);

  logic [VW-1:0] r_val;
  logic [PW-1:0] r_pos;
  logic          w_gt;
  logic          w_shift;
  logic          w_load;

  // Strict compare keeps equal values in arrival order; the OR chain marks every
  // slot at or right of the insertion point so they shift up by one.
  always_comb begin
    w_gt    = (i_slot < i_k) && (r_val > i_new_val);
    o_gt_c  = i_gt_left | w_gt;
    w_shift = i_gt_left && (i_slot <= i_k);
    w_load  = !i_gt_left && (w_gt || (i_slot == i_k));
  end

  // Slot storage: cleared on reset or accepted start, updated on each insertion.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_val <= '0;
      r_pos <= '0;
    end else if (i_en) begin
      if (w_shift) begin
        r_val <= i_left_val;
        r_pos <= i_left_pos;
      end else if (w_load) begin
        r_val <= i_new_val;
        r_pos <= i_new_pos;
      end
    end
  end

  assign o_val = r_val;
  assign o_pos = r_pos;

endmodule

// File: rtl/insert_sort.sv
// Sequential insertion sorter: captures a vector on sortstart, inserts one element
// per clock into a cell array, then holds the ascending result with its source indices.
module insert_sort
  import insert_sort_pkg::*;
#(
  parameter int unsigned INPUTVALS      = 64,
  parameter int unsigned INPUTBITWIDTHS = 16,
  localparam int unsigned PW            = pos_w(INPUTVALS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      sortstart,
  input  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  needs_sorting,
  output logic                                      sortdone,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  sorted,
  output logic [INPUTVALS-1:0][PW-1:0]              sorted_positions,
  output logic                                      error
);

  localparam int unsigned VW     = INPUTBITWIDTHS;
  localparam int unsigned KW     = $clog2(INPUTVALS);
  localparam logic [KW-1:0] K_LAST = KW'(INPUTVALS - 1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [KW-1:0]                   r_k;
  logic [INPUTVALS-1:0][VW-1:0]    r_buf;
  logic                            r_sortdone;
  logic                            r_error;
  logic                            w_start_acc;
  logic                            w_ins_en;
  logic                            w_busy_start;
  logic                            w_last;
  logic [VW-1:0]                   w_new_val;
  logic [PW-1:0]                   w_new_pos;
  logic [INPUTVALS-1:0]            w_gt_chain;
  logic                            w_unused_gt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_acc  = 1'b0;
    w_ins_en     = 1'b0;
    w_busy_start = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (sortstart) begin
          w_start_acc = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_ins_en     = 1'b1;
        w_busy_start = sortstart;
        w_last       = (r_k == K_LAST);
        if (w_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Insertion index: cleared on start, advances once per insertion.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc)     r_k <= '0;
    else if (w_ins_en && !w_last) r_k <= r_k + KW'(1);
  end

  // Input buffer: the vector is sampled only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst)              r_buf <= '0;
    else if (w_start_acc) r_buf <= needs_sorting;
  end

  // Done level rises the cycle after the FSM reaches DONE and drops on restart.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc)     r_sortdone <= 1'b0;
    else if (r_state == DONE)   r_sortdone <= 1'b1;
  end

  // Sticky flag for a start request that arrived while sorting.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) r_error <= 1'b0;
    else if (w_busy_start)  r_error <= 1'b1;
  end

  assign w_new_val = r_buf[r_k];
  assign w_new_pos = PW'(r_k);
  assign sortdone  = r_sortdone;
  assign error     = r_error;

  for (genvar g = 0; g < INPUTVALS; g++) begin : g_cell
    logic          w_gt_left;
    logic [VW-1:0] w_left_val;
    logic [PW-1:0] w_left_pos;

    if (g == 0) begin : g_first
      assign w_gt_left  = 1'b0;
      assign w_left_val = '0;
      assign w_left_pos = '0;
    end else begin : g_rest
      assign w_gt_left  = w_gt_chain[g-1];
      assign w_left_val = sorted[g-1];
      assign w_left_pos = sorted_positions[g-1];
    end

    insert_sort_cell #(
      .VW (VW),
      .PW (PW),
      .KW (KW)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_start_acc),
      .i_en       (w_ins_en),
      .i_slot     (KW'(g)),
      .i_k        (r_k),
      .i_new_val  (w_new_val),
      .i_new_pos  (w_new_pos),
      .i_left_val (w_left_val),
      .i_left_pos (w_left_pos),
      .i_gt_left  (w_gt_left),
      .o_gt_c     (w_gt_chain[g]),
      .o_val      (sorted[g]),
      .o_pos      (sorted_positions[g])
    );
  end

  // The rightmost slot has no neighbour to feed.
  assign w_unused_gt = w_gt_chain[INPUTVALS-1];

endmodule

// File: tb/tb_insert_sort.sv
// Scoreboard bench for insert_sort: the driver queues expected results at each
// accepted start, the monitor compares them when sortdone rises.
module tb_insert_sort;

  localparam int N       = 64;
  localparam int W       = 16;
  localparam int PW      = 7;
  localparam int LATENCY = 65;

  typedef logic [N-1:0][W-1:0]  vec_t;
  typedef logic [N-1:0][PW-1:0] pvec_t;
  typedef struct {
    vec_t  s;
    pvec_t p;
    logic  err;
    int    t0;
    string name;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  sortstart;
  vec_t  needs_sorting;
  logic  sortdone;
  vec_t  sorted;
  pvec_t sorted_positions;
  logic  error;

  exp_t  sb[$];
  exp_t  m_e;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  logic  prev_done = 1'b0;

  insert_sort #(
    .INPUTVALS      (N),
    .INPUTBITWIDTHS (W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sortstart        (sortstart),
    .needs_sorting    (needs_sorting),
    .sortdone         (sortdone),
    .sorted           (sorted),
    .sorted_positions (sorted_positions),
    .error            (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Stable ascending reference: rank = smaller values plus earlier equal values.
  function automatic exp_t model(input vec_t v, input string nm);
    exp_t e;
    int   rank;
    e.s = '0;
    e.p = '0;
    for (int i = 0; i < N; i++) begin
      rank = 0;
      for (int j = 0; j < N; j++)
        if ((v[j] < v[i]) || ((v[j] == v[i]) && (j < i))) rank++;
      e.s[rank] = v[i];
      e.p[rank] = PW'(i);
    end
    e.err  = 1'b0;
    e.t0   = 0;
    e.name = nm;
    return e;
  endfunction

  task automatic start_sort(input vec_t v, input string nm, input logic exp_err, input bit push);
    exp_t e;
    @(negedge clk);
    needs_sorting = v;
    sortstart     = 1'b1;
    if (push) begin
      e     = model(v, nm);
      e.err = exp_err;
      e.t0  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    sortstart     = 1'b0;
    needs_sorting = ~v;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compare a queued expectation on every rising edge of sortdone.
  always @(negedge clk) begin
    if (sortdone && !prev_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_e = sb.pop_front();
        check($sformatf("%s latency", m_e.name), 32'(cyc - m_e.t0), 32'(LATENCY));
        check($sformatf("%s error", m_e.name), 32'(error), 32'(m_e.err));
        for (int i = 0; i < N; i++) begin
          check($sformatf("%s sorted[%0d]", m_e.name, i), 32'(sorted[i]), 32'(m_e.s[i]));
          check($sformatf("%s pos[%0d]", m_e.name, i), 32'(sorted_positions[i]), 32'(m_e.p[i]));
        end
      end
    end
    prev_done = sortdone;
  end

  initial begin
    vec_t v;
    rst           = 1'b1;
    sortstart     = 1'b0;
    needs_sorting = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset sortdone", 32'(sortdone), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset sorted zero", 32'(sorted == '0), 32'd1);
    check("reset pos zero", 32'(sorted_positions == '0), 32'd1);

    // Random values
    for (int i = 0; i < N; i++) v[i] = W'($urandom);
    start_sort(v, "random", 1'b0, 1'b1);
    wait_done();

    // Reverse order
    for (int i = 0; i < N; i++) v[i] = W'(N - 1 - i);
    start_sort(v, "reverse", 1'b0, 1'b1);
    wait_done();
    check("reverse sorted[0]", 32'(sorted[0]), 32'd0);
    check("reverse pos[0]", 32'(sorted_positions[0]), 32'd63);

    // All equal: stability
    for (int i = 0; i < N; i++) v[i] = 16'h1234;
    start_sort(v, "equal", 1'b0, 1'b1);
    wait_done();
    check("equal pos[10]", 32'(sorted_positions[10]), 32'd10);

    // Extremes
    for (int i = 0; i < N; i++) v[i] = W'(i * 1031 + 7);
    v[5]  = 16'hFFFF;
    v[40] = 16'h0000;
    v[41] = 16'hFFFF;
    start_sort(v, "extremes", 1'b0, 1'b1);
    wait_done();
    check("extremes sorted[0]", 32'(sorted[0]), 32'h0);
    check("extremes sorted[63]", 32'(sorted[63]), 32'hFFFF);
    check("extremes pos[63]", 32'(sorted_positions[63]), 32'd41);

    // Start while busy
    for (int i = 0; i < N; i++) v[i] = W'((i * 37) % 50);
    start_sort(v, "busy_start", 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    sortstart     = 1'b1;
    needs_sorting = '0;
    @(negedge clk);
    sortstart = 1'b0;
    check("busy_start error set", 32'(error), 32'd1);
    check("busy_start still busy", 32'(sortdone), 32'd0);
    wait_done();
    for (int i = 0; i < N; i++) v[i] = W'(N - 1 - i);
    start_sort(v, "after_error", 1'b0, 1'b1);
    check("error cleared", 32'(error), 32'd0);
    wait_done();

    // Reset mid-sort
    for (int i = 0; i < N; i++) v[i] = W'($urandom);
    start_sort(v, "aborted", 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort sortdone", 32'(sortdone), 32'd0);
    check("abort sorted zero", 32'(sorted == '0), 32'd1);
    check("abort pos zero", 32'(sorted_positions == '0), 32'd1);
    check("abort error", 32'(error), 32'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("abort stays idle", 32'(sortdone), 32'd0);
    for (int i = 0; i < N; i++) v[i] = W'($urandom);
    start_sort(v, "post_reset", 1'b0, 1'b1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
